// File: rtl/instruction_fetch_if.sv
// Fetch-stage signal bundle: instruction-memory request bus, branch redirect
// input and the decode-facing instruction handshake. The fetch stage is the
// master; memory, the redirect source and decode together form the slave side.
// Handshake semantics:
//   - IMemReq/IMemAck: IMemReq holds IMemAddr stable until a one-cycle
//     IMemAck returns IMemData.
//   - InstrValid/InstrReady: the head entry transfers on any rising edge
//     where both are 1. InstrValid never depends on InstrReady.
interface instruction_fetch_if;
  logic        IMemReq;
  logic [63:0] IMemAddr;
  logic        IMemAck;
  logic [31:0] IMemData;
  logic        PCSrc;
  logic [63:0] BranchAddress;
  logic [31:0] InstructionI;
  logic [63:0] AddressI;
  logic        InstrValid;
  logic        InstrReady;

  modport master (
    output IMemReq, IMemAddr, InstructionI, AddressI, InstrValid,
    input  IMemAck, IMemData, PCSrc, BranchAddress, InstrReady
  );

  modport slave (
    input  IMemReq, IMemAddr, InstructionI, AddressI, InstrValid,
    output IMemAck, IMemData, PCSrc, BranchAddress, InstrReady
  );
endinterface

// File: rtl/instruction_fetch.sv
// LEGv8 instruction fetch stage. Issues one memory request at a time and
// buffers returned words in a DEPTH-entry queue for decode. A redirect
// (PCSrc) flushes the queue, and any request still in flight is marked
// stale: it is completed on the bus but its data is discarded.
module instruction_fetch #(
  parameter logic [63:0] RESET_PC = 64'h0,
  parameter int          DEPTH    = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  instruction_fetch_if.master  bus,
  output logic [1:0]           dbg_state
);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  // FETCH: idle, may launch. WAIT: live request. DROP: stale request.
  typedef enum logic [1:0] {FETCH = 2'd0, WAIT = 2'd1, DROP = 2'd2} state_e;

  state_e           state, state_nxt;
  logic [63:0]      pc;
  logic [63:0]      imem_addr_q;
  logic [31:0]      q_instr [DEPTH];
  logic [63:0]      q_addr  [DEPTH];
  logic [PTR_W-1:0] rd_ptr, wr_ptr, rd_ptr_inc;
  logic [CNT_W-1:0] count;
  logic [31:0]      head_instr;
  logic [63:0]      head_addr;
  logic             redirect, launch, push, pop;
  logic [63:0]      target;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
  endfunction

  assign target     = {bus.BranchAddress[63:2], 2'b00};
  assign redirect   = bus.PCSrc;
  // A request is only launched with room left, so a push never meets a full queue.
  assign launch     = (state == FETCH) && !redirect && (count < FULL_CNT);
  // A redirect in the ack cycle discards the word.
  assign push       = (state == WAIT) && bus.IMemAck && !redirect;
  // A flush overrides a pop in the same cycle.
  assign pop        = (count != '0) && bus.InstrReady && !redirect;
  assign rd_ptr_inc = ptr_inc(rd_ptr);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= FETCH;
    else        state <= state_nxt;
  end

  // Next-state logic: every ack returns to FETCH; a redirect mid-request turns it stale.
  always_comb begin
    state_nxt = state;
    unique case (state)
      FETCH:   if (launch) state_nxt = WAIT;
      WAIT:    if (bus.IMemAck) state_nxt = FETCH;
               else if (redirect) state_nxt = DROP;
      DROP:    if (bus.IMemAck) state_nxt = FETCH;
      default: state_nxt = FETCH;
    endcase
  end

  // FSM outputs: the request is live in any non-idle state, so reset drops it at once.
  always_comb begin
    bus.IMemReq = (state != FETCH);
    dbg_state   = state;
  end

  // PC and request address: redirects always retarget the PC, even in WAIT/DROP.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc          <= RESET_PC;
      imem_addr_q <= 64'h0;
    end else if (redirect) begin
      pc <= target;
    end else if (launch) begin
      imem_addr_q <= pc;
      pc          <= pc + 64'd4;
    end
  end

  // Queue pointers and occupancy; a flush empties the queue.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (redirect) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= rd_ptr_inc;
      if (push && !pop)      count <= count + CNT_W'(1);
      else if (pop && !push) count <= count - CNT_W'(1);
    end
  end

  // Queue storage: payload only, validity is tracked by count.
  always_ff @(posedge clk) begin
    if (push) begin
      q_instr[wr_ptr] <= bus.IMemData;
      q_addr[wr_ptr]  <= imem_addr_q;
    end
  end

  // Registered head: it tracks the next head entry, and it holds its last value when the queue empties.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_instr <= 32'h0;
      head_addr  <= 64'h0;
    end else if (!redirect) begin
      if (pop && (count > CNT_W'(1))) begin
        head_instr <= q_instr[rd_ptr_inc];
        head_addr  <= q_addr[rd_ptr_inc];
      end else if (push && ((count == '0) || pop)) begin
        head_instr <= bus.IMemData;
        head_addr  <= imem_addr_q;
      end
    end
  end

  assign bus.IMemAddr     = imem_addr_q;
  assign bus.InstrValid   = (count != '0);
  assign bus.InstructionI = head_instr;
  assign bus.AddressI     = head_addr;
endmodule

// File: tb/tb_instruction_fetch.sv
// Randomized bench for instruction_fetch. A transaction-level model tracks
// the expected fetch address stream, the queued addresses (exp_q) and whether
// the outstanding request went stale. The memory returns a word derived from
// its address, so each delivered word can be checked.
module tb_instruction_fetch;
  localparam logic [63:0] RESET_PC = 64'h100;
  localparam int          DEPTH    = 2;

  logic       clk;
  logic       rst_n;
  logic [1:0] dbg_state;

  instruction_fetch_if bus();

  instruction_fetch #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // Clock and watchdog.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: sim time expired, required finish before 2000000");
    $fatal(1, "watchdog");
  end

  // Scoreboard state.
  int          n_checks = 0;
  int          n_pass   = 0;
  logic [63:0] exp_q[$];
  logic [63:0] exp_pc;
  logic        stale;
  logic        prev_req;
  logic [63:0] cur_addr;
  int          lat;
  logic [63:0] last_head_addr;
  logic [31:0] last_head_instr;
  int          delivered;
  logic        force_redir;
  logic [63:0] force_tgt;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
  endtask

  function automatic logic [31:0] imem_word(input logic [63:0] a);
    logic [63:0] t;
    t = a;
    return t[33:2] ^ 32'h9E37_79B9;
  endfunction

  task automatic model_reset();
    exp_q.delete();
    exp_pc          = RESET_PC;
    stale           = 1'b0;
    prev_req        = 1'b0;
    cur_addr        = 64'h0;
    lat             = 0;
    last_head_addr  = 64'h0;
    last_head_instr = 32'h0;
  endtask

  task automatic drive_idle();
    bus.IMemAck       = 1'b0;
    bus.IMemData      = 32'h0;
    bus.PCSrc         = 1'b0;
    bus.BranchAddress = 64'h0;
    bus.InstrReady    = 1'b0;
  endtask

  // One clock cycle, entered and left at a falling edge.
  task automatic step(input int ready_pct, input int redir_pct, input int max_lat);
    logic        req_now, ack, pcs, rdy, exp_req_next;
    logic [63:0] tgt;
    req_now = bus.IMemReq;
    if (req_now && !prev_req) begin
      check_eq("req_addr", bus.IMemAddr, exp_pc);
      exp_pc   = exp_pc + 64'd4;
      cur_addr = bus.IMemAddr;
      lat      = $urandom_range(0, max_lat);
    end else if (req_now) begin
      check_eq("addr_stable", bus.IMemAddr, cur_addr);
    end
    check_eq("valid", {63'b0, bus.InstrValid}, {63'b0, exp_q.size() != 0});
    if (exp_q.size() != 0) begin
      last_head_addr  = exp_q[0];
      last_head_instr = imem_word(exp_q[0]);
    end
    check_eq("head_addr", bus.AddressI, last_head_addr);
    check_eq("head_instr", {32'b0, bus.InstructionI}, {32'b0, last_head_instr});

    ack = req_now && (lat == 0);
    if (req_now && lat != 0) lat--;
    if (force_redir) begin
      pcs = 1'b1;
      tgt = force_tgt;
      force_redir = 1'b0;
    end else begin
      pcs = ($urandom_range(0, 99) < redir_pct);
      tgt = ($urandom_range(0, 7) == 0) ? 64'hFFFF_FFFF_FFFF_FFFF
                                        : {32'h0, $urandom_range(0, 32'hFFFF)};
    end
    rdy = ($urandom_range(0, 99) < ready_pct);
    bus.IMemAck       = ack;
    bus.IMemData      = ack ? imem_word(cur_addr) : $urandom;
    bus.PCSrc         = pcs;
    bus.BranchAddress = pcs ? tgt : {$urandom, $urandom};
    bus.InstrReady    = rdy;

    exp_req_next = req_now ? !ack : (!pcs && exp_q.size() < DEPTH);
    if (pcs) begin
      exp_q.delete();
      exp_pc = {tgt[63:2], 2'b00};
      if (ack) stale = 1'b0;
      else if (req_now) stale = 1'b1;
    end else begin
      if (rdy && exp_q.size() != 0) begin
        void'(exp_q.pop_front());
        delivered++;
      end
      if (ack) begin
        if (!stale) exp_q.push_back(cur_addr);
        stale = 1'b0;
      end
    end
    prev_req = req_now;
    @(negedge clk);
    check_eq("req", {63'b0, bus.IMemReq}, {63'b0, exp_req_next});
  endtask

  task automatic run(input int n, input int ready_pct, input int redir_pct, input int max_lat);
    for (int i = 0; i < n; i++) step(ready_pct, redir_pct, max_lat);
  endtask

  initial begin
    rst_n       = 1'b0;
    force_redir = 1'b0;
    force_tgt   = 64'h0;
    delivered   = 0;
    drive_idle();
    model_reset();
    repeat (2) @(negedge clk);
    check_eq("rst_req", {63'b0, bus.IMemReq}, 64'h0);
    check_eq("rst_addr", bus.IMemAddr, 64'h0);
    check_eq("rst_valid", {63'b0, bus.InstrValid}, 64'h0);
    check_eq("rst_instr", {32'b0, bus.InstructionI}, 64'h0);
    check_eq("rst_addri", bus.AddressI, 64'h0);
    rst_n = 1'b1;

    // Sequential fetch with minimum memory latency and decode always ready.
    run(20, 100, 0, 0);
    // Backpressure fills the queue, then drains.
    run(20, 0, 0, 1);
    check_eq("full_valid", {63'b0, bus.InstrValid}, 64'h1);
    check_eq("full_noreq", {63'b0, bus.IMemReq}, 64'h0);
    run(20, 100, 0, 1);
    // Mixed random traffic with redirects and slow memory.
    run(2000, 60, 10, 3);
    // Wrap: a misaligned target near the top of the address space.
    force_redir = 1'b1;
    force_tgt   = 64'hFFFF_FFFF_FFFF_FFFF;
    run(30, 100, 0, 2);

    // Reset abort while a request is outstanding.
    for (int i = 0; i < 50 && !bus.IMemReq; i++) step(50, 0, 3);
    check_eq("abort_pre_req", {63'b0, bus.IMemReq}, 64'h1);
    #2 rst_n = 1'b0;
    #1;
    check_eq("abort_req", {63'b0, bus.IMemReq}, 64'h0);
    check_eq("abort_valid", {63'b0, bus.InstrValid}, 64'h0);
    check_eq("abort_addr", bus.IMemAddr, 64'h0);
    drive_idle();
    @(negedge clk);
    bus.IMemAck  = 1'b1;
    bus.IMemData = 32'hDEAD_BEEF;
    @(negedge clk);
    drive_idle();
    model_reset();
    rst_n = 1'b1;
    run(20, 100, 0, 0);
    run(500, 50, 15, 3);

    check_eq("progress", {63'b0, delivered >= 50}, 64'h1);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/instruction_fetch.md
# instruction_fetch

Instruction fetch stage for the LEGv8 pipeline. It drives the instruction address toward instruction memory and buffers the returned words in a small queue. It presents `InstructionI`/`AddressI` to the decode stage with a valid/ready handshake. It consumes the `PCSrc`/`BranchAddress` redirect that the decode/execute path produces, so it is the producer side of decode's input and the consumer side of its branch output.

## Interface
- `RESET_PC`, 64'h0: PC loaded at reset.
- `DEPTH`, 2: fetch queue entries (≥1).
- `clk` in 1: sole clock, rising edge.
- `rst_n` in 1: reset, asynchronous assert, active-low.
- `IMemReq` out 1: instruction memory request, held until ack.
- `IMemAddr` out 64: request address, stable while `IMemReq`=1.
- `IMemAck` in 1: one-cycle pulse, data valid this cycle; only meaningful while `IMemReq`=1.
- `IMemData` in 32: returned instruction word.
- `PCSrc` in 1: one-cycle redirect pulse.
- `BranchAddress` in 64: redirect target, sampled when `PCSrc`=1.
- `InstructionI` out 32: head-of-queue instruction.
- `AddressI` out 64: address of `InstructionI`.
- `InstrValid` out 1: queue non-empty.
- `InstrReady` in 1: decode accepts the head entry.

## Operation
- Registers:
  - `PC`: next address to fetch.
  - `IMemAddr`: own register.
  - queue of `DEPTH` {instr, addr} entries with `count`.
  - state ∈ {FETCH, WAIT, DROP}.
- `IMemReq` = (state ≠ FETCH).
- **FETCH:** if `PCSrc`=1, then PC←{BranchAddress[63:2],2'b00} and the queue is flushed; stay in FETCH. Else if `count` < `DEPTH`, then IMemAddr←PC, PC←PC+4, and go to WAIT. Else stay in FETCH.
- **WAIT:**
  - `PCSrc`=1 with `IMemAck`=1: discard the data, flush the queue, PC←aligned target, go to FETCH.
  - `PCSrc`=1 with `IMemAck`=0: flush the queue, PC←aligned target, go to DROP.
  - `IMemAck`=1 only: push {IMemData, IMemAddr}, go to FETCH.
- **DROP:** keep `IMemReq`/`IMemAddr` unchanged until `IMemAck`. On ack, discard the data and go to FETCH. A further `PCSrc` in DROP updates PC (last redirect wins) and stays in DROP, or goes to FETCH if ack arrives in the same cycle.
- **Pop:** when `InstrValid` & `InstrReady`, remove the head.
  - Flush overrides pop and push in the same cycle.
  - Push and pop in the same cycle leave `count` unchanged.
  - Push is never issued when full: a request is only launched with `count` < `DEPTH`, and pops only decrease `count`.
- **Addresses:** PC arithmetic is mod 2^64; 64'hFFFF_FFFF_FFFF_FFFC + 4 wraps to 0. `BranchAddress` bits [1:0] are ignored (forced 0).
- **Head outputs:** `InstructionI`/`AddressI` hold the head entry. When empty they hold their last value and `InstrValid`=0.

## Timing
- **Reset values:**
  - state=FETCH, PC=`RESET_PC`, `count`=0.
  - `IMemReq`=0, `IMemAddr`=0, `InstrValid`=0.
  - `InstructionI`=32'h0, `AddressI`=64'h0.
- Reset asserted mid-request drops the outstanding request immediately (`IMemReq`→0 asynchronously). An ack arriving afterward is ignored.
- **Fetch latency:**
  - `IMemReq` rises on the first clock edge after reset release.
  - With ack one cycle later, `InstrValid` rises the edge after the ack.
  - Fetch-to-valid latency is 2 cycles at minimum memory latency.
- **Throughput:** at most one instruction per 2 cycles, because each ack returns to FETCH.
- **Redirect:** `PCSrc` at edge N puts the target on `IMemAddr` at the earliest at edge N+1 from FETCH, or one cycle after the stale ack from WAIT/DROP. No stale word is ever pushed after a redirect.
- `InstrValid` is combinational from `count`. `InstrReady` has no combinational path to any output.

## Test plan
- **Reset/sequential fetch:** `RESET_PC`=0x100, memory acks 1 cycle after req, `InstrReady`=1 → `IMemAddr` sequence 0x100, 0x104, 0x108. Decode sees `AddressI` 0x100 first, with `InstrValid` 2 cycles after the first `IMemReq`.
- **Backpressure:** `InstrReady`=0, `DEPTH`=2 → exactly 2 acks are accepted, then `IMemReq` stays 0. Raising `InstrReady` pops 0x100 then 0x104 in order, and fetch resumes at 0x108.
- **Redirect while waiting:** memory latency 3; `PCSrc`=1 with `BranchAddress`=0x2003 in the cycle after the req → `IMemAddr` is held until the ack and that word is not delivered. The next request is to 0x2000, and the queue is empty in between.
- **Redirect with simultaneous ack and pop:** queue holds 1 entry; `PCSrc`, `IMemAck` and `InstrReady` are all 1 in the same cycle → `count`=0 next cycle, the acked word is dropped, and the next `IMemAddr` is the target.
- **Double redirect in DROP:** targets 0x3000 then 0x4000 before the ack → the first fetch after the ack is 0x4000.
- **Wrap and reset abort:** redirect to 0xFFFF_FFFF_FFFF_FFFC gives next fetches 0xFFFF_FFFF_FFFF_FFFC then 0x0. Asserting `rst_n`=0 mid-WAIT forces `IMemReq`=0 at once, and fetch restarts at `RESET_PC`.
